// File: rtl/swan_kat_bist.sv
// swan_kat_bist: known-answer-test sequencer for a serial SWAN cipher core.
// Walks an external, combinational vector ROM and drives the core through
// encrypt, decrypt or round-trip checks. It accumulates an aggregate pass/fail,
// a saturating failure count and the index of the first failing vector.
module swan_kat_bist #(
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned KEY_SIZE   = 256,
  parameter int unsigned NUM_VEC    = 4,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bist_start,
  input  logic [1:0]            mode,
  output logic [IDX_W-1:0]      vec_idx,
  input  logic [KEY_SIZE-1:0]   vec_key,
  input  logic [BLOCK_SIZE-1:0] vec_pt,
  input  logic [BLOCK_SIZE-1:0] vec_ct,
  output logic                  core_start,
  output logic                  core_dec,
  output logic [KEY_SIZE-1:0]   core_key,
  output logic [BLOCK_SIZE-1:0] core_inp,
  input  logic                  core_ready,
  input  logic [BLOCK_SIZE-1:0] core_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [IDX_W:0]        err_cnt,
  output logic [IDX_W-1:0]      first_fail
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_rt;        // round-trip run (mode 2 or 3)
  logic                  r_fix_dec;   // fixed phase for single-direction runs
  logic                  r_phase;     // 0 = encrypt phase, 1 = decrypt phase
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [BLOCK_SIZE-1:0] r_result;

  logic [IDX_W-1:0]      r_vec_idx;
  logic                  r_core_start;
  logic                  r_core_dec;
  logic [KEY_SIZE-1:0]   r_core_key;
  logic [BLOCK_SIZE-1:0] r_core_inp;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_timeout;
  logic [IDX_W:0]        r_err_cnt;
  logic [IDX_W-1:0]      r_first_fail;

  logic [BLOCK_SIZE-1:0] w_expected;
  logic                  w_mismatch;
  logic [IDX_W:0]        w_err_inc;
  logic                  w_first_err;
  logic                  w_last_vec;
  logic [BLOCK_SIZE-1:0] w_issue_inp;

  // Compare target, saturating error increment and next core input block.
  always_comb begin
    w_expected  = r_phase ? vec_pt : vec_ct;
    w_mismatch  = (r_result != w_expected);
    w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
    w_first_err = (r_err_cnt == '0);
    w_last_vec  = (r_vec_idx == LAST_IDX);
    w_issue_inp = vec_pt;
    if (r_phase) begin
      w_issue_inp = r_rt ? r_result : vec_ct;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rt         <= 1'b0;
      r_fix_dec    <= 1'b0;
      r_phase      <= 1'b0;
      r_wait_cnt   <= '0;
      r_result     <= '0;
      r_vec_idx    <= '0;
      r_core_start <= 1'b0;
      r_core_dec   <= 1'b0;
      r_core_key   <= '0;
      r_core_inp   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else begin
      r_core_start <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bist_start) begin
            r_rt         <= mode[1];
            r_fix_dec    <= (mode == 2'd1);
            r_phase      <= (mode == 2'd1);
            r_vec_idx    <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_timeout    <= 1'b0;
            r_pass       <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        // Key/input are registered here from the ROM, so the start pulse is
        // launched together with them and is visible in the first WAIT cycle.
        S_ISSUE: begin
          r_core_key   <= vec_key;
          r_core_inp   <= w_issue_inp;
          r_core_dec   <= r_phase;
          r_core_start <= 1'b1;
          r_wait_cnt   <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            r_result <= core_out;
            r_state  <= S_CHECK;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_err_cnt <= w_err_inc;
            if (w_first_err) begin
              r_first_fail <= r_vec_idx;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err_cnt <= w_err_inc;
            if (w_first_err) begin
              r_first_fail <= r_vec_idx;
            end
          end
          if (r_rt && !r_phase) begin
            r_phase <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last_vec) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_cnt == '0) && !r_timeout;
            r_state <= S_DONE;
          end else begin
            r_vec_idx <= r_vec_idx + 1'b1;
            r_phase   <= r_fix_dec;
            r_state   <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_idx    = r_vec_idx;
  assign core_start = r_core_start;
  assign core_dec   = r_core_dec;
  assign core_key   = r_core_key;
  assign core_inp   = r_core_inp;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_swan_kat_bist.sv
// tb_swan_kat_bist: table-driven and randomized checks of the KAT sequencer
// against a behavioural core stub and a vector-level reference model.
module tb_swan_kat_bist;

  localparam logic [255:0] PT3 = {4{64'hf0debc9a78563412}};
  localparam logic [255:0] CT3 = 256'h5e7f7837ab855ba2666046be47c2b93a435db79615506e3128b7fd3d1a0f22c2;
  localparam logic [255:0] MIX = {8{32'h9e3779b9}};

  logic         clk = 1'b0;
  logic         rst;
  logic         bist_start;
  logic [1:0]   mode;
  logic [1:0]   vec_idx;
  logic [255:0] vec_key, vec_pt, vec_ct;
  logic         core_start, core_dec;
  logic [255:0] core_key, core_inp;
  logic         core_ready = 1'b0;
  logic [255:0] core_out = '0;
  logic         busy, done, pass, timeout;
  logic [2:0]   err_cnt;
  logic [1:0]   first_fail;

  always #5 clk = ~clk;

  swan_kat_bist #(
    .BLOCK_SIZE(256),
    .KEY_SIZE  (256),
    .NUM_VEC   (4),
    .IDX_W     (2),
    .TIMEOUT   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bist_start(bist_start),
    .mode      (mode),
    .vec_idx   (vec_idx),
    .vec_key   (vec_key),
    .vec_pt    (vec_pt),
    .vec_ct    (vec_ct),
    .core_start(core_start),
    .core_dec  (core_dec),
    .core_key  (core_key),
    .core_inp  (core_inp),
    .core_ready(core_ready),
    .core_out  (core_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_cnt   (err_cnt),
    .first_fail(first_fail)
  );

  // ROM seen by the DUT (possibly corrupted) and its combinational read port
  logic [255:0] rom_key [4];
  logic [255:0] rom_pt  [4];
  logic [255:0] rom_ct  [4];
  assign vec_key = rom_key[vec_idx];
  assign vec_pt  = rom_pt[vec_idx];
  assign vec_ct  = rom_ct[vec_idx];

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Ideal core: vector 3 is a genuine SWAN256 answer; other inputs use an
  // invertible stand-in cipher. A faulty core returns zero.
  function automatic logic [255:0] core_fn(input logic dec, input logic [255:0] k,
                                           input logic [255:0] x, input bit fault);
    logic [255:0] rk;
    if (fault) return '0;
    rk = {k[127:0], k[255:128]};
    if (!dec) return (k == '1 && x == PT3) ? CT3 : (x ^ rk ^ MIX);
    return (k == '1 && x == CT3) ? PT3 : (x ^ rk ^ MIX);
  endfunction

  task automatic load_rom(input logic [3:0] corrupt);
    for (int v = 0; v < 4; v++) begin
      if (v == 3) begin
        rom_key[v] = '1;
        rom_pt[v]  = PT3;
        rom_ct[v]  = CT3;
      end else begin
        rom_key[v] = rnd256();
        rom_pt[v]  = rnd256();
        rom_ct[v]  = core_fn(1'b0, rom_key[v], rom_pt[v], 1'b0);
      end
      if (corrupt[v]) rom_ct[v][0] = ~rom_ct[v][0];
    end
  endtask

  // Behavioural core stub
  int unsigned c_lat = 2, c_hold = 1;
  bit          c_fault = 1'b0, c_hang = 1'b0, stray_req = 1'b0;
  int unsigned cdown = 0, hold_cnt = 0;
  logic [255:0] pend;

  always @(negedge clk) begin
    if (rst) begin
      cdown = 0;
      hold_cnt = 0;
      core_ready = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) core_ready = 1'b0;
      end
      if (cdown > 0) begin
        cdown--;
        if (cdown == 0) begin
          core_ready = 1'b1;
          core_out   = pend;
          hold_cnt   = c_hold;
        end
      end
      if (core_start) begin
        core_ready = 1'b0;
        hold_cnt   = 0;
        if (!c_hang) begin
          pend  = core_fn(core_dec, core_key, core_inp, c_fault);
          cdown = c_lat;
        end
      end
      if (stray_req) begin
        core_ready = 1'b1;
        core_out   = rnd256();
        hold_cnt   = 1;
      end
    end
  end

  // Monitor of issued core operations
  typedef struct packed {
    logic         dec;
    logic [255:0] key;
    logic [255:0] inp;
  } op_t;
  op_t         obs_ops[$];
  int unsigned dbl_cnt = 0;
  logic        prev_cs = 1'b0;

  always @(negedge clk) begin
    if (!rst && core_start) begin
      obs_ops.push_back(op_t'{core_dec, core_key, core_inp});
      if (prev_cs) dbl_cnt++;
    end
    prev_cs = core_start;
  end

  // Reference model: expected operations and verdict for a whole run
  op_t         exp_ops[$];
  int unsigned exp_err, exp_ff;
  bit          exp_pass;

  task automatic model_run(input int m, input bit fault);
    int unsigned fails;
    bit          hit;
    logic [255:0] r, r2;
    fails = 0; hit = 0; exp_ff = 0;
    exp_ops.delete();
    for (int v = 0; v < 4; v++) begin
      if (m == 1) begin
        exp_ops.push_back(op_t'{1'b1, rom_key[v], rom_ct[v]});
        r = core_fn(1'b1, rom_key[v], rom_ct[v], fault);
        if (r != rom_pt[v]) begin if (!hit) exp_ff = v; hit = 1; fails++; end
      end else begin
        exp_ops.push_back(op_t'{1'b0, rom_key[v], rom_pt[v]});
        r = core_fn(1'b0, rom_key[v], rom_pt[v], fault);
        if (r != rom_ct[v]) begin if (!hit) exp_ff = v; hit = 1; fails++; end
        if (m != 0) begin
          exp_ops.push_back(op_t'{1'b1, rom_key[v], r});
          r2 = core_fn(1'b1, rom_key[v], r, fault);
          if (r2 != rom_pt[v]) begin if (!hit) exp_ff = v; hit = 1; fails++; end
        end
      end
    end
    exp_err  = (fails > 7) ? 7 : fails;
    exp_pass = (fails == 0);
  endtask

  task automatic cmp_ops(input string pfx, input int unsigned base);
    int unsigned nobs, nd;
    nobs = obs_ops.size() - base;
    nd = 0;
    check({pfx, "_nops"}, 64'(nobs), 64'(exp_ops.size()));
    for (int unsigned i = 0; i < exp_ops.size() && base + i < obs_ops.size(); i++)
      if (obs_ops[base + i] !== exp_ops[i]) nd++;
    check({pfx, "_ops"}, 64'(nd), 64'd0);
  endtask

  task automatic wait_done(input string pfx);
    int unsigned cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    check({pfx, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic do_run(input string pfx, input logic [1:0] m, output int unsigned base);
    base = obs_ops.size();
    @(negedge clk); mode = m; bist_start = 1'b1;
    @(negedge clk); bist_start = 1'b0;
    wait_done(pfx);
  endtask

  typedef struct {
    int         mode;
    logic [3:0] corrupt;
    int         lat;
    int         err;
    int         ff;
    bit         ps;
    int         starts;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, n;
    string       nm;
    logic [1:0]  m;
    logic [3:0]  cm;

    tbl[0] = '{0, 4'b0000, 3,  0, 0, 1'b1, 4};
    tbl[1] = '{2, 4'b0000, 2,  0, 0, 1'b1, 8};
    tbl[2] = '{1, 4'b0010, 4,  1, 1, 1'b0, 4};
    tbl[3] = '{0, 4'b0010, 1,  1, 1, 1'b0, 4};
    tbl[4] = '{2, 4'b0010, 5,  1, 1, 1'b0, 8};
    tbl[5] = '{3, 4'b1100, 2,  2, 2, 1'b0, 8};
    tbl[6] = '{1, 4'b1001, 19, 2, 0, 1'b0, 4};

    rst = 1'b1; bist_start = 1'b0; mode = 2'd0;
    load_rom(4'b0000);
    repeat (3) @(negedge clk);
    check("rst_vec_idx", 64'(vec_idx), 0);
    check("rst_core_start", 64'(core_start), 0);
    check("rst_core_dec", 64'(core_dec), 0);
    check("rst_core_key", 64'(|core_key), 0);
    check("rst_core_inp", 64'(|core_inp), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_pass", 64'(pass), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_err_cnt", 64'(err_cnt), 0);
    check("rst_first_fail", 64'(first_fail), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven runs with hand-derived verdicts
    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("tbl%0d", i);
      load_rom(tbl[i].corrupt);
      c_lat = tbl[i].lat; c_hold = 1; c_fault = 0; c_hang = 0;
      model_run(tbl[i].mode, 1'b0);
      do_run(nm, 2'(tbl[i].mode), base);
      check({nm, "_pass"}, 64'(pass), 64'(tbl[i].ps));
      check({nm, "_err"}, 64'(err_cnt), 64'(tbl[i].err));
      check({nm, "_ff"}, 64'(first_fail), 64'(tbl[i].ff));
      check({nm, "_timeout"}, 64'(timeout), 0);
      check({nm, "_busy"}, 64'(busy), 0);
      check({nm, "_starts"}, 64'(obs_ops.size() - base), 64'(tbl[i].starts));
      cmp_ops(nm, base);
    end

    // Randomized runs against the reference model
    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("rnd%0d", i);
      m  = 2'($urandom_range(0, 3));
      cm = 4'($urandom);
      load_rom(cm);
      c_lat = $urandom_range(1, 19); c_hold = $urandom_range(1, 2);
      c_fault = ($urandom_range(0, 4) == 0); c_hang = 0;
      model_run(m, c_fault);
      do_run(nm, m, base);
      check({nm, "_pass"}, 64'(pass), 64'(exp_pass));
      check({nm, "_err"}, 64'(err_cnt), 64'(exp_err));
      check({nm, "_ff"}, 64'(first_fail), 64'(exp_ff));
      check({nm, "_timeout"}, 64'(timeout), 0);
      cmp_ops(nm, base);
    end

    // Error counter saturation: faulty core, 8 failing checks
    load_rom(4'b0000);
    c_lat = 2; c_hold = 1; c_fault = 1; c_hang = 0;
    do_run("sat", 2'd2, base);
    check("sat_err", 64'(err_cnt), 64'd7);
    check("sat_ff", 64'(first_fail), 0);
    check("sat_pass", 64'(pass), 0);
    c_fault = 0;

    // Core never ready: timeout exactly 20 cycles after WAIT entry
    c_hang = 1;
    base = obs_ops.size();
    @(negedge clk); mode = 2'd0; bist_start = 1'b1;
    @(negedge clk); bist_start = 1'b0;
    n = 0;
    while (core_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("to_start_seen", 64'(core_start), 1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("to_cycles", 64'(n), 64'd20);
    check("to_timeout", 64'(timeout), 1);
    check("to_err", 64'(err_cnt), 1);
    check("to_pass", 64'(pass), 0);
    check("to_ff", 64'(first_fail), 0);
    check("to_starts", 64'(obs_ops.size() - base), 1);
    c_hang = 0;

    // Reset in WAIT on vector 2, then a clean rerun from vector 0
    load_rom(4'b0000);
    c_lat = 15; c_hold = 1;
    @(negedge clk); mode = 2'd0; bist_start = 1'b1;
    @(negedge clk); bist_start = 1'b0;
    n = 0;
    while (!(vec_idx == 2'd2 && core_start === 1'b1) && n < 1000) begin @(negedge clk); n++; end
    check("rstw_reach", 64'(vec_idx == 2'd2 && core_start === 1'b1), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstw_busy", 64'(busy), 0);
    check("rstw_vec_idx", 64'(vec_idx), 0);
    check("rstw_core_start", 64'(core_start), 0);
    check("rstw_core_key", 64'(|core_key), 0);
    check("rstw_core_inp", 64'(|core_inp), 0);
    check("rstw_done", 64'(done), 0);
    @(negedge clk); rst = 1'b0;
    c_lat = 3;
    model_run(0, 1'b0);
    do_run("rstw_rerun", 2'd0, base);
    check("rstw_rerun_pass", 64'(pass), 1);
    cmp_ops("rstw_rerun", base);

    // Stray core_ready in IDLE, then bist_start held through two runs
    base = obs_ops.size();
    @(negedge clk); #1 stray_req = 1'b1;
    @(negedge clk); #1 stray_req = 1'b0;
    @(negedge clk);
    check("stray_busy", 64'(busy), 0);
    check("stray_starts", 64'(obs_ops.size() - base), 0);
    load_rom(4'b0000);
    c_lat = 2; c_hold = 1;
    model_run(0, 1'b0);
    base = obs_ops.size();
    @(negedge clk); mode = 2'd0; bist_start = 1'b1;
    @(negedge clk);
    wait_done("held1");
    check("held1_pass", 64'(pass), 1);
    cmp_ops("held1", base);
    @(negedge clk);
    check("held_restart_done", 64'(done), 0);
    check("held_restart_busy", 64'(busy), 1);
    check("held_restart_idx", 64'(vec_idx), 0);
    base = obs_ops.size();
    bist_start = 1'b0;
    wait_done("held2");
    check("held2_pass", 64'(pass), 1);
    cmp_ops("held2", base);

    check("start_pulse_width", 64'(dbl_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
